lhn_seq_mult_ctrl: RTL
======================

LHN_SEQ_MULT_CTRL -- requirements
Module: lhn_seq_mult_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 7, giving the operand width; it SHALL equal the width of the external ripple adder it drives.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Resetn, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply.
REQ-005 The block SHALL have ports a and b, input, W each, the unsigned multiplicand and multiplier, sampled only on start acceptance.
REQ-006 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-007 The block SHALL have port done, output, 1, a single-cycle pulse when product is updated.
REQ-008 The block SHALL have port product, output, 2W, the registered unsigned result.
REQ-009 The block SHALL have ports add_x and add_y, output, W each, and add_cin, output, 1, which drive the external adder.
REQ-010 The block SHALL have ports add_s, input, W, and add_cout, input, 1, which return the adder's sum and carry.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, a sampled start=1 SHALL:
  - latch M<=a, P_lo<=b, P_hi<=0 and cnt<=0;
  - move the FSM to RUN.
REQ-013 Each RUN cycle SHALL drive the adder combinationally with add_x=P_hi, add_y=(P_lo[0] ? M : 0) and add_cin=0.
REQ-014 On each RUN edge the block SHALL update {P_hi,P_lo} <= {add_cout, add_s, P_lo} >> 1 and increment cnt.
REQ-015 After exactly W RUN cycles, the block SHALL load product <= {P_hi,P_lo} (post-shift value) and move to DONE.
REQ-016 Latency SHALL be W+1 edges from the start-sampling edge to the edge after which done=1 (8 for W=7).
REQ-017 done SHALL be high only while in DONE, for exactly one cycle.
REQ-018 DONE SHALL go to IDLE when start=0, and to RUN when start=1 (back-to-back operation).
REQ-019 busy SHALL equal (state==RUN).
REQ-020 start SHALL be ignored while in RUN; a, b and M SHALL NOT change mid-operation.
REQ-021 product SHALL hold its value until the next DONE load.
REQ-022 Outside RUN, the adder outputs SHALL be add_x=0, add_y=0 and add_cin=0.
REQ-023 The maximal operands a=b=2^W-1 SHALL produce the exact result with no truncation, as add_cout is captured every cycle.

Reset
REQ-024 Resetn=0 SHALL immediately force the following, regardless of the clock, including mid-RUN, where the partial result is discarded:
  - state=IDLE;
  - busy=0 and done=0;
  - product=0;
  - M, P_hi, P_lo and cnt all =0.
REQ-025 The first start after reset release SHALL behave as per REQ-012.

Configuration
REQ-026 With macro LHN_MULT_OVF_EN defined, the block SHALL:
  - add port ovf, output, 1;
  - load ovf = (upper W bits of the result != 0) together with product;
  - reset ovf to 0.
REQ-027 Without LHN_MULT_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 The shared package SHALL hold:
  - the default width constant (7);
  - the FSM state enum (IDLE, RUN, DONE);
  - the counter width constant, clog2(W+1).
REQ-029 The block SHALL contain no adder; it SHALL use the external adder through the add_* ports, and the bench SHALL wire the team's W-bit ripple adder to them.
REQ-030 The block SHALL have no sub-module; the FSM and datapath registers SHALL be in the single module.

Verification
REQ-031 The bench SHALL cover: a=5, b=3, start pulse -> busy for 7 cycles, done one cycle, product=0x000F.
REQ-032 The bench SHALL cover: a=0x7F, b=0x7F -> product=0x3F01, and ovf=1 when LHN_MULT_OVF_EN is defined.
REQ-033 The bench SHALL cover: a=0x7F, b=0 -> product=0x0000, ovf=0, with latency still 8 edges.
REQ-034 The bench SHALL cover: start held high across the run with a, b changed mid-RUN -> the result uses the originally latched operands, and a new run begins directly from DONE.
REQ-035 The bench SHALL cover: Resetn asserted at RUN cycle 3 -> busy, done and product are 0 immediately; the next start of 2x6 gives product=0x000C.

Source files
------------

// File: rtl/lhn_seq_mult_ctrl_pkg.sv
// lhn_seq_mult_ctrl_pkg: shared width constants and FSM state type for the sequential multiplier
package lhn_seq_mult_ctrl_pkg;
  localparam int DEF_W = 7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_width(DEF_W);
endpackage

// File: rtl/lhn_seq_mult_ctrl_if.sv
// lhn_seq_mult_ctrl_if: multiply request/result and external adder bus; ovf present only with LHN_MULT_OVF_EN
interface lhn_seq_mult_ctrl_if
  import lhn_seq_mult_ctrl_pkg::*;
#(parameter int W = DEF_W);
  logic start;
  logic [W-1:0] a, b;
  logic busy, done;
  logic [2*W-1:0] product;
  logic [W-1:0] add_x, add_y, add_s;
  logic add_cin, add_cout;
`ifdef LHN_MULT_OVF_EN
  logic ovf;
  modport master (output start, a, b, add_s, add_cout,
                  input busy, done, product, add_x, add_y, add_cin, ovf);
  modport slave (input start, a, b, add_s, add_cout,
                 output busy, done, product, add_x, add_y, add_cin, ovf);
`else
  modport master (output start, a, b, add_s, add_cout,
                  input busy, done, product, add_x, add_y, add_cin);
  modport slave (input start, a, b, add_s, add_cout,
                 output busy, done, product, add_x, add_y, add_cin);
`endif
endinterface

// File: rtl/lhn_seq_mult_ctrl.sv
// lhn_seq_mult_ctrl: shift-add unsigned multiplier controller using an external W-bit adder; LHN_MULT_OVF_EN adds ovf
module lhn_seq_mult_ctrl
  import lhn_seq_mult_ctrl_pkg::*;
#(parameter int W = DEF_W) (
  input logic Clock,
  input logic Resetn,
  lhn_seq_mult_ctrl_if.slave bus
);
  localparam int CW = cnt_width(W);
  state_t state;
  logic [W-1:0] m, p_hi, p_lo, nx_hi, nx_lo;
  logic [CW-1:0] cnt;
  logic run;
  assign run = state == RUN;
  assign {nx_hi, nx_lo} = {bus.add_cout, bus.add_s, p_lo[W-1:1]};
  assign bus.add_x = run ? p_hi : '0;
  assign bus.add_y = (run && p_lo[0]) ? m : '0;
  assign bus.add_cin = 1'b0;
  // FSM, shift-add datapath and registered busy/done/product
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.product <= '0;
      m <= '0;
      p_hi <= '0;
      p_lo <= '0;
      cnt <= '0;
`ifdef LHN_MULT_OVF_EN
      bus.ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          state <= bus.start ? RUN : IDLE;
          if (bus.start) begin
            m <= bus.a;
            p_lo <= bus.b;
            p_hi <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          p_hi <= nx_hi;
          p_lo <= nx_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            bus.product <= {nx_hi, nx_lo};
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
`ifdef LHN_MULT_OVF_EN
            bus.ovf <= |nx_hi;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
